// File: rtl/ctrl_decode_pipe.sv
// Control decoder for the pipelined RV32 subset core: main + ALU decode in D,
// with control bits carried through E/M/W pipeline registers to their consumers.
module ctrl_decode_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       LoadD,
  output logic       ByteD,
  output logic       ALUSrcE,
  output logic       ByteW,
  output logic       MemtoRegW,
  output logic [2:0] ALUControl
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_IALU = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;

  logic       w_reg_write_d;
  logic       w_mem_write_d;
  logic       w_alu_src_d;
  logic       w_memtoreg_d;
  logic       w_load_d;
  logic       w_byte_d;
  logic [1:0] w_aluop_d;
  logic [2:0] w_alu_ctrl_d;
  logic       w_mem_f3_ok;

  logic       r_reg_write_e;
  logic       r_mem_write_e;
  logic       r_alu_src_e;
  logic       r_memtoreg_e;
  logic       r_byte_e;
  logic [2:0] r_alu_ctrl_e;

  logic       r_reg_write_m;
  logic       r_mem_write_m;
  logic       r_memtoreg_m;
  logic       r_byte_m;

  logic       r_reg_write_w;
  logic       r_memtoreg_w;
  logic       r_byte_w;

  // Only LB/LW/SB/SW are legal memory widths; anything else decodes as a bubble.
  assign w_mem_f3_ok = (funct3 == F3_BYTE) || (funct3 == F3_WORD);

  always_comb begin
    w_reg_write_d = 1'b0;
    w_mem_write_d = 1'b0;
    w_alu_src_d   = 1'b0;
    w_memtoreg_d  = 1'b0;
    w_load_d      = 1'b0;
    w_byte_d      = 1'b0;
    w_aluop_d     = ALUOP_ADD;
    unique case (opcode)
      OP_R: begin
        w_reg_write_d = 1'b1;
        w_aluop_d     = ALUOP_RTYP;
      end
      OP_IALU: begin
        w_reg_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
        w_aluop_d     = ALUOP_IALU;
      end
      OP_LOAD: begin
        if (w_mem_f3_ok) begin
          w_reg_write_d = 1'b1;
          w_alu_src_d   = 1'b1;
          w_memtoreg_d  = 1'b1;
          w_load_d      = 1'b1;
          w_byte_d      = (funct3 == F3_BYTE);
        end
      end
      OP_STORE: begin
        if (w_mem_f3_ok) begin
          w_mem_write_d = 1'b1;
          w_alu_src_d   = 1'b1;
          w_byte_d      = (funct3 == F3_BYTE);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_ctrl_d = ALU_ADD;
    unique case (w_aluop_d)
      ALUOP_ADD:  w_alu_ctrl_d = ALU_ADD;
      ALUOP_SUB:  w_alu_ctrl_d = ALU_SUB;
      ALUOP_IALU: w_alu_ctrl_d = ALU_ADD;
      ALUOP_RTYP: begin
        unique case (funct7)
          F7_ADD:  w_alu_ctrl_d = ALU_ADD;
          F7_SUB:  w_alu_ctrl_d = ALU_SUB;
          F7_MUL:  w_alu_ctrl_d = ALU_MUL;
          default: w_alu_ctrl_d = ALU_ADD;
        endcase
      end
      default: w_alu_ctrl_d = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_write_e <= 1'b0;
      r_mem_write_e <= 1'b0;
      r_alu_src_e   <= 1'b0;
      r_memtoreg_e  <= 1'b0;
      r_byte_e      <= 1'b0;
      r_alu_ctrl_e  <= ALU_ADD;
    end else begin
      r_reg_write_e <= w_reg_write_d;
      r_mem_write_e <= w_mem_write_d;
      r_alu_src_e   <= w_alu_src_d;
      r_memtoreg_e  <= w_memtoreg_d;
      r_byte_e      <= w_byte_d;
      r_alu_ctrl_e  <= w_alu_ctrl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_write_m <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_memtoreg_m  <= 1'b0;
      r_byte_m      <= 1'b0;
    end else begin
      r_reg_write_m <= r_reg_write_e;
      r_mem_write_m <= r_mem_write_e;
      r_memtoreg_m  <= r_memtoreg_e;
      r_byte_m      <= r_byte_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_write_w <= 1'b0;
      r_memtoreg_w  <= 1'b0;
      r_byte_w      <= 1'b0;
    end else begin
      r_reg_write_w <= r_reg_write_m;
      r_memtoreg_w  <= r_memtoreg_m;
      r_byte_w      <= r_byte_m;
    end
  end

  // D-stage hazard hints are purely combinational and ignore reset.
  assign LoadD      = w_load_d;
  assign ByteD      = w_byte_d;
  assign ALUSrcE    = r_alu_src_e;
  assign ALUControl = r_alu_ctrl_e;
  assign MemWrite   = r_mem_write_m;
  assign RegWrite   = r_reg_write_w;
  assign MemtoRegW  = r_memtoreg_w;
  assign ByteW      = r_byte_w;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe; registered outputs are packed as
// {RegWrite, MemWrite, ALUSrcE, ByteW, MemtoRegW, ALUControl[2:0]}.
module tb_ctrl_decode_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       RegWrite;
  logic       MemWrite;
  logic       LoadD;
  logic       ByteD;
  logic       ALUSrcE;
  logic       ByteW;
  logic       MemtoRegW;
  logic [2:0] ALUControl;

  logic [7:0] w_obs;
  logic [7:0] w_obs_d;

  int n_checks = 0;
  int n_pass   = 0;

  ctrl_decode_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .LoadD      (LoadD),
    .ByteD      (ByteD),
    .ALUSrcE    (ALUSrcE),
    .ByteW      (ByteW),
    .MemtoRegW  (MemtoRegW),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  assign w_obs   = {RegWrite, MemWrite, ALUSrcE, ByteW, MemtoRegW, ALUControl};
  assign w_obs_d = {6'b0, LoadD, ByteD};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction surrounded by bubbles and follow it through E, M, W.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [7:0] exp_d,
                           input logic [7:0] exp_e, input logic [7:0] exp_m,
                           input logic [7:0] exp_w);
    drive(op, f3, f7);
    #1;
    chk({tag, "_d"}, w_obs_d, exp_d);
    step();
    chk({tag, "_e"}, w_obs, exp_e);
    drive(7'b0, 3'b0, 7'b0);
    step();
    chk({tag, "_m"}, w_obs, exp_m);
    step();
    chk({tag, "_w"}, w_obs, exp_w);
  endtask

  initial begin
    reset = 1'b0;
    drive(7'b0000011, 3'b000, 7'b0);  // LB held in D while in reset
    #1;
    chk("rst_loadd_ungated", w_obs_d, 8'h03);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", w_obs, 8'h00);
    end
    reset = 1'b1;
    drive(7'b0, 3'b0, 7'b0);
    #1;
    chk("rst_release", w_obs, 8'h00);
    step();
    chk("rst_post1", w_obs, 8'h00);
    step();
    chk("rst_post2", w_obs, 8'h00);
    step();
    chk("rst_post3", w_obs, 8'h00);

    run_instr("sub",       7'b0110011, 3'b000, 7'b0100000, 8'h00, 8'h01, 8'h00, 8'h80);
    run_instr("lb",        7'b0000011, 3'b000, 7'b0000000, 8'h03, 8'h20, 8'h00, 8'h98);
    run_instr("lw",        7'b0000011, 3'b010, 7'b0000000, 8'h02, 8'h20, 8'h00, 8'h88);
    run_instr("sw",        7'b0100011, 3'b010, 7'b0000000, 8'h00, 8'h20, 8'h40, 8'h00);
    run_instr("ialu_f7",   7'b0010011, 3'b101, 7'b0100000, 8'h00, 8'h20, 8'h00, 8'h80);
    run_instr("r_f7other", 7'b0110011, 3'b000, 7'b0100001, 8'h00, 8'h00, 8'h00, 8'h80);
    run_instr("ld_badf3",  7'b0000011, 3'b001, 7'b0000000, 8'h00, 8'h00, 8'h00, 8'h00);
    run_instr("st_badf3",  7'b0100011, 3'b100, 7'b0000000, 8'h00, 8'h00, 8'h00, 8'h00);

    // Back-to-back: ADD, MUL, SB, illegal.
    drive(7'b0110011, 3'b000, 7'b0000000);
    #1;
    chk("str_add_d", w_obs_d, 8'h00);
    step();
    chk("str_e1", w_obs, 8'h00);
    drive(7'b0110011, 3'b000, 7'b0000001);
    #1;
    chk("str_mul_d", w_obs_d, 8'h00);
    step();
    chk("str_e2", w_obs, 8'h02);
    drive(7'b0100011, 3'b000, 7'b0000000);
    #1;
    chk("str_sb_d", w_obs_d, 8'h01);
    step();
    chk("str_e3", w_obs, 8'hA0);
    drive(7'b1111111, 3'b000, 7'b0000000);
    #1;
    chk("str_ill_d", w_obs_d, 8'h00);
    step();
    chk("str_e4", w_obs, 8'hC0);
    drive(7'b0, 3'b0, 7'b0);
    step();
    chk("str_e5", w_obs, 8'h10);
    step();
    chk("str_e6", w_obs, 8'h00);

    // SW squashed by reset one cycle after it enters.
    drive(7'b0100011, 3'b010, 7'b0000000);
    step();
    chk("sq_e", w_obs, 8'h20);
    reset = 1'b0;
    drive(7'b0, 3'b0, 7'b0);
    step();
    chk("sq_m", w_obs, 8'h00);
    step();
    chk("sq_w", w_obs, 8'h00);
    reset = 1'b1;
    step();
    chk("sq_post1", w_obs, 8'h00);
    step();
    chk("sq_post2", w_obs, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
